// File: rtl/checkpoint_allocator.sv
// Branch checkpoint slot allocator: circular FIFO of checkpoint IDs with
// out-of-order release, in-order reclaim, and recover/flush truncation.
module checkpoint_allocator #(
  parameter  int CHECKPOINT_COUNT = 8,
  parameter  int ROB_IDX_W        = 7,
  localparam int CK_W             = $clog2(CHECKPOINT_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_req,
  input  logic [ROB_IDX_W-1:0]        alloc_rob_idx,
  output logic                        alloc_gnt,
  output logic [CK_W-1:0]             alloc_id,
  output logic                        snap_we,
  input  logic                        release_valid,
  input  logic [CK_W-1:0]             release_id,
  input  logic                        recover_valid,
  input  logic [CK_W-1:0]             recover_id,
  input  logic                        flush_all,
  output logic [CK_W:0]               count,
  output logic                        full,
  output logic                        empty,
  output logic [CK_W-1:0]             head_id,
  output logic [ROB_IDX_W-1:0]        head_rob_idx,
  output logic [CHECKPOINT_COUNT-1:0] live_mask,
  output logic                        err
);
  localparam int N = CHECKPOINT_COUNT;

  logic [CK_W-1:0]      r_head;
  logic [CK_W-1:0]      r_tail;
  logic [CK_W:0]        r_count;
  logic [N-1:0]         r_live;
  logic [N-1:0]         r_done;
  logic [ROB_IDX_W-1:0] r_rob_idx [N];
  logic                 r_err;

  logic            w_full;
  logic            w_gnt;
  logic            w_rec_ok;
  logic            w_rel_ok;
  logic            w_rel_drop;
  logic            w_rel_err;
  logic            w_reclaim;
  logic            w_err_nxt;
  logic [CK_W-1:0] w_rec_off;
  logic [N-1:0]    w_discard;
  logic [N-1:0]    w_live_nxt;
  logic [N-1:0]    w_done_nxt;

  assign w_full     = (r_count == (CK_W+1)'(N));
  assign w_gnt      = alloc_req & ~w_full & ~recover_valid & ~flush_all;
  assign w_rec_ok   = recover_valid & r_live[recover_id];
  assign w_rec_off  = recover_id - r_head;
  assign w_rel_ok   = release_valid & r_live[release_id] & ~r_done[release_id];
  assign w_rel_drop = w_rec_ok & w_discard[release_id];
  assign w_rel_err  = release_valid & ~w_rel_ok & ~w_rel_drop;
  assign w_reclaim  = (r_count != '0) & r_done[r_head] & ~w_rec_ok;
  assign w_err_nxt  = r_err | (~flush_all & (w_rel_err | (recover_valid & ~w_rec_ok)));

  // A slot is discarded by recover when its age (distance from head) is at
  // least that of recover_id; age ordering stays correct when full.
  always_comb begin
    w_discard = '0;
    for (int i = 0; i < N; i++) begin
      w_discard[i] = r_live[i] && ((CK_W'(i) - r_head) >= w_rec_off);
    end
  end

  // NOTE: combinational next-state uses blocking '=' with defaults assigned
  // first, so every path is covered and no latch is inferred.
  always_comb begin
    w_live_nxt = r_live;
    w_done_nxt = r_done;
    if (w_rec_ok) begin
      w_live_nxt = r_live & ~w_discard;
      w_done_nxt = r_done & ~w_discard;
    end else begin
      if (w_reclaim) begin
        w_live_nxt[r_head] = 1'b0;
        w_done_nxt[r_head] = 1'b0;
      end
      if (w_gnt) begin
        w_live_nxt[r_tail] = 1'b1;
        w_done_nxt[r_tail] = 1'b0;
      end
    end
    if (w_rel_ok && !w_rel_drop) w_done_nxt[release_id] = 1'b1;
    if (flush_all) begin
      w_live_nxt = '0;
      w_done_nxt = '0;
    end
  end

  // NOTE: registers use non-blocking '<=' so all state updates see the
  // pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_live  <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_live <= w_live_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (flush_all) begin
        r_head  <= r_tail;
        r_count <= '0;
      end else if (w_rec_ok) begin
        r_tail  <= recover_id;
        r_count <= {1'b0, w_rec_off};
      end else begin
        if (w_reclaim) r_head <= r_head + 1'b1;
        if (w_gnt)     r_tail <= r_tail + 1'b1;
        unique case ({w_gnt, w_reclaim})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: the ROB-index array is payload qualified by live, so it is left
  // unreset and can map onto plain storage.
  always_ff @(posedge clk) begin
    if (w_gnt) r_rob_idx[r_tail] <= alloc_rob_idx;
  end

  assign alloc_gnt    = w_gnt;
  assign alloc_id     = r_tail;
  assign snap_we      = w_gnt;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = (r_count == '0);
  assign head_id      = r_head;
  assign head_rob_idx = r_rob_idx[r_head];
  assign live_mask    = r_live;
  assign err          = r_err;
endmodule

// File: tb/tb_checkpoint_allocator.sv
// Directed self-checking bench for checkpoint_allocator (8 slots, 7-bit ROB index).
module tb_checkpoint_allocator;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_req = 1'b0;
  logic [6:0] alloc_rob_idx = '0;
  logic       alloc_gnt;
  logic [2:0] alloc_id;
  logic       snap_we;
  logic       release_valid = 1'b0;
  logic [2:0] release_id = '0;
  logic       recover_valid = 1'b0;
  logic [2:0] recover_id = '0;
  logic       flush_all = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic [2:0] head_id;
  logic [6:0] head_rob_idx;
  logic [7:0] live_mask;
  logic       err;

  int n_pass  = 0;
  int n_total = 0;

  checkpoint_allocator #(.CHECKPOINT_COUNT(8), .ROB_IDX_W(7)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_rob_idx(alloc_rob_idx),
    .alloc_gnt(alloc_gnt), .alloc_id(alloc_id), .snap_we(snap_we),
    .release_valid(release_valid), .release_id(release_id),
    .recover_valid(recover_valid), .recover_id(recover_id),
    .flush_all(flush_all),
    .count(count), .full(full), .empty(empty),
    .head_id(head_id), .head_rob_idx(head_rob_idx),
    .live_mask(live_mask), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic alloc_n(input int n, input int rob_base);
    for (int i = 0; i < n; i++) begin
      alloc_req     = 1'b1;
      alloc_rob_idx = 7'(rob_base + i);
      tick();
    end
    alloc_req = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); else n_pass++;
    n_total++; if (alloc_gnt !== 1'b0) $display("FAIL reset_gnt got %b exp 0", alloc_gnt); else n_pass++;
    n_total++; if (live_mask !== 8'h00 || err !== 1'b0) $display("FAIL reset_state got live=%h err=%b exp 00/0", live_mask, err); else n_pass++;
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      alloc_req     = 1'b1;
      alloc_rob_idx = 7'(10 + i);
      #1;
      n_total++;
      if (alloc_gnt !== 1'b1 || snap_we !== 1'b1 || alloc_id !== 3'(i))
        $display("FAIL fill_grant_%0d got gnt=%b we=%b id=%0d exp 1/1/%0d", i, alloc_gnt, snap_we, alloc_id, i);
      else n_pass++;
      tick();
    end
    #1;
    n_total++; if (full !== 1'b1 || count !== 4'd8) $display("FAIL fill_full got full=%b count=%0d exp 1/8", full, count); else n_pass++;
    n_total++; if (alloc_gnt !== 1'b0) $display("FAIL fill_ninth_gnt got %b exp 0", alloc_gnt); else n_pass++;
    n_total++; if (head_rob_idx !== 7'd10 || live_mask !== 8'hff) $display("FAIL fill_head got rob=%0d live=%h exp 10/ff", head_rob_idx, live_mask); else n_pass++;
    tick();
    alloc_req = 1'b0;
    n_total++; if (count !== 4'd8) $display("FAIL fill_hold got %0d exp 8", count); else n_pass++;
    flush_all = 1'b1;
    tick();
    flush_all = 1'b0;
    n_total++; if (count !== 4'd0 || empty !== 1'b1 || live_mask !== 8'h00) $display("FAIL fill_flush got count=%0d empty=%b live=%h exp 0/1/00", count, empty, live_mask); else n_pass++;
  endtask

  task automatic test_async_reset();
    alloc_n(5, 40);
    n_total++; if (count !== 4'd5) $display("FAIL areset_pre got %0d exp 5", count); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if (count !== 4'd0 || empty !== 1'b1 || live_mask !== 8'h00) $display("FAIL areset_now got count=%0d empty=%b live=%h exp 0/1/00", count, empty, live_mask); else n_pass++;
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_release_reclaim();
    alloc_n(3, 20);
    release_valid = 1'b1;
    release_id    = 3'd2;
    tick();
    release_id    = 3'd0;
    tick();
    release_valid = 1'b0;
    n_total++; if (count !== 4'd3 || head_id !== 3'd0) $display("FAIL rr_before got count=%0d head=%0d exp 3/0", count, head_id); else n_pass++;
    tick();
    n_total++; if (count !== 4'd2 || head_id !== 3'd1 || live_mask !== 8'h06) $display("FAIL rr_slot0 got count=%0d head=%0d live=%h exp 2/1/06", count, head_id, live_mask); else n_pass++;
    n_total++; if (head_rob_idx !== 7'd21) $display("FAIL rr_head_rob got %0d exp 21", head_rob_idx); else n_pass++;
    tick();
    n_total++; if (count !== 4'd2 || live_mask !== 8'h06) $display("FAIL rr_slot2_held got count=%0d live=%h exp 2/06", count, live_mask); else n_pass++;
    release_valid = 1'b1;
    release_id    = 3'd1;
    tick();
    release_valid = 1'b0;
    tick();
    n_total++; if (count !== 4'd1 || head_id !== 3'd2) $display("FAIL rr_slot1 got count=%0d head=%0d exp 1/2", count, head_id); else n_pass++;
    tick();
    n_total++; if (count !== 4'd0 || head_id !== 3'd3 || empty !== 1'b1) $display("FAIL rr_slot2 got count=%0d head=%0d empty=%b exp 0/3/1", count, head_id, empty); else n_pass++;
  endtask

  task automatic test_recover();
    do_reset();
    alloc_n(6, 50);
    alloc_req     = 1'b1;
    recover_valid = 1'b1;
    recover_id    = 3'd3;
    release_valid = 1'b1;
    release_id    = 3'd4;
    #1;
    n_total++; if (alloc_gnt !== 1'b0 || snap_we !== 1'b0) $display("FAIL rec_gnt got gnt=%b we=%b exp 0/0", alloc_gnt, snap_we); else n_pass++;
    tick();
    recover_valid = 1'b0;
    release_valid = 1'b0;
    #1;
    n_total++; if (count !== 4'd3 || live_mask !== 8'h07) $display("FAIL rec_state got count=%0d live=%h exp 3/07", count, live_mask); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rec_drop_err got %b exp 0", err); else n_pass++;
    n_total++; if (alloc_id !== 3'd3 || alloc_gnt !== 1'b1) $display("FAIL rec_next_id got id=%0d gnt=%b exp 3/1", alloc_id, alloc_gnt); else n_pass++;
    tick();
    alloc_req = 1'b0;
    n_total++; if (count !== 4'd4 || live_mask !== 8'h0f) $display("FAIL rec_realloc got count=%0d live=%h exp 4/0f", count, live_mask); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    alloc_n(6, 60);
    for (int i = 0; i < 6; i++) begin
      release_valid = 1'b1;
      release_id    = 3'(i);
      tick();
    end
    release_valid = 1'b0;
    tick();
    tick();
    n_total++; if (count !== 4'd0 || head_id !== 3'd6) $display("FAIL wrap_drain got count=%0d head=%0d exp 0/6", count, head_id); else n_pass++;
    alloc_n(4, 70);
    n_total++; if (count !== 4'd4 || live_mask !== 8'hc3 || alloc_id !== 3'd2) $display("FAIL wrap_fill got count=%0d live=%h tail=%0d exp 4/c3/2", count, live_mask, alloc_id); else n_pass++;
    recover_valid = 1'b1;
    recover_id    = 3'd7;
    tick();
    recover_valid = 1'b0;
    n_total++; if (count !== 4'd1 || live_mask !== 8'h40 || alloc_id !== 3'd7 || head_id !== 3'd6) $display("FAIL wrap_recover got count=%0d live=%h tail=%0d head=%0d exp 1/40/7/6", count, live_mask, alloc_id, head_id); else n_pass++;
  endtask

  task automatic test_err_flush();
    release_valid = 1'b1;
    release_id    = 3'd4;
    tick();
    release_valid = 1'b0;
    n_total++; if (err !== 1'b1 || count !== 4'd1 || live_mask !== 8'h40) $display("FAIL err_set got err=%b count=%0d live=%h exp 1/1/40", err, count, live_mask); else n_pass++;
    tick();
    tick();
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err); else n_pass++;
    alloc_n(5, 80);
    n_total++; if (count !== 4'd6) $display("FAIL err_refill got %0d exp 6", count); else n_pass++;
    flush_all = 1'b1;
    alloc_req = 1'b1;
    #1;
    n_total++; if (alloc_gnt !== 1'b0) $display("FAIL flush_gnt got %b exp 0", alloc_gnt); else n_pass++;
    tick();
    flush_all = 1'b0;
    alloc_req = 1'b0;
    n_total++; if (count !== 4'd0 || empty !== 1'b1 || live_mask !== 8'h00) $display("FAIL flush_state got count=%0d empty=%b live=%h exp 0/1/00", count, empty, live_mask); else n_pass++;
    n_total++; if (err !== 1'b1 || head_id !== 3'd4) $display("FAIL flush_keep got err=%b head=%0d exp 1/4", err, head_id); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_async_reset();
    test_release_reclaim();
    test_recover();
    test_wrap();
    test_err_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/checkpoint_allocator.md
Name:
checkpoint_allocator

Overview:
- Owns the CHECKPOINT_COUNT branch checkpoint slots that the rename stage snapshots into and that RecoveryUnit restores from.
- Sits between rename/dispatch (allocation requester), BranchExecute (correct-resolution release) and RecoveryUnit (restore/flush), so that checkpoint IDs are never double-allocated or leaked.
- Slots are allocated in program order as a circular FIFO. They are released out of order and reclaimed in order.

Parameters:
CHECKPOINT_COUNT, 8, number of checkpoint slots (power of two, >=2)
ROB_IDX_W, 7, width of ROB index tagged to each checkpoint
CK_W, $clog2(CHECKPOINT_COUNT), checkpoint ID width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
alloc_req  in  1  rename requests a checkpoint for a branch this cycle
alloc_rob_idx  in  ROB_IDX_W  ROB index of that branch
alloc_gnt  out  1  grant; the slot in alloc_id is taken at this edge
alloc_id  out  CK_W  ID granted (equals tail pointer)
snap_we  out  1  copy RAT/FreeList into slot alloc_id (equals alloc_gnt)
release_valid  in  1  branch resolved correctly; its checkpoint is no longer needed
release_id  in  CK_W  checkpoint being released
recover_valid  in  1  restore pulse (RecoveryUnit rat_restore)
recover_id  in  CK_W  checkpoint restored; it and all younger slots are discarded
flush_all  in  1  exception flush; discard every slot
count  out  CK_W+1  live slots
full  out  1  count == CHECKPOINT_COUNT
empty  out  1  count == 0
head_id  out  CK_W  oldest live slot
head_rob_idx  out  ROB_IDX_W  ROB index tagged to head_id
live_mask  out  CHECKPOINT_COUNT  bit i = slot i allocated
err  out  1  sticky; illegal release/recover seen

Behaviour:
- State is head, tail, count, live[N], done[N] and rob_idx[N].
- Reset (rst low, asynchronous) clears head, tail, count, live, done and err. Outputs after reset are empty=1, full=0, alloc_gnt=0, count=0.

Allocation:
- alloc_gnt = alloc_req & !full & !recover_valid & !flush_all. This is combinational on registered full; a same-cycle pop does not open a slot.
- On grant at the edge: live[tail]<=1, done[tail]<=0, rob_idx[tail]<=alloc_rob_idx, tail<=tail+1 (mod N).

Release:
- release_valid with live[release_id]=1 and done=0 sets done[release_id].
- A release of a non-live or already-done ID is ignored and sets err.

Reclaim:
- Each cycle, if count>0 & done[head]: live[head]<=0, done[head]<=0, head<=head+1.
- At most one slot is reclaimed per cycle.

Recover:
- Precondition: live[recover_id]=1, otherwise err is set and the pulse is ignored.
- All slots from recover_id through tail-1 (mod N) clear live and done.
- tail<=recover_id, count<=(recover_id-head) mod N.
- If recover_id==head, count becomes 0.
- Reclaim is suppressed in the recover cycle.

flush_all:
- head<=tail, count<=0, live<=0, done<=0. err is retained.

Priority:
- flush_all > recover_valid > {alloc, release, reclaim}.
- A release targeting a slot discarded by the same-cycle recover is dropped without err.

Count update:
- count += grant - reclaim.
- A simultaneous grant and reclaim leaves count unchanged.
- count never exceeds N and never underflows.

Wrap-around:
- Pointers wrap mod N. full/empty are derived from count, not from pointer equality.

Latency:
- Grant is same cycle.
- Release-to-reclaim is at least 1 cycle after done is set, provided the slot is head.

Test Plan:
- Reset low mid-run with count=5 -> count=0, empty=1, live_mask=0 immediately, without waiting for a clock edge.
- 8 back-to-back alloc_req -> alloc_id 0..7, full=1 after the 8th; 9th req gives alloc_gnt=0.
- Alloc 0,1,2; release 2 then 0 -> slot 0 reclaimed next cycle, head_id=1, count=2; slot 2 stays until 1 is released, then 1 and 2 are reclaimed on consecutive cycles.
- Alloc 0..5 (head=0); recover_id=3 with alloc_req high -> alloc_gnt=0, count=3, tail=3, live_mask=8'b0000_0111; next alloc gets id 3.
- Wrap: head=6, tail=2 (count=4); recover_id=7 -> count=1, live_mask=8'b0100_0000, tail=7.
- Release of non-live id 4 -> err=1 sticky, state unchanged. flush_all with count=6 -> count=0, err still 1.
